// File: rtl/trace_monitor.sv
// Retire-event trace monitor: packs each active RUN cycle into a timestamped
// record and buffers it in a FIFO that a consumer drains over valid/ready.
module trace_monitor #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 16,
    parameter int REG_W      = 4,
    parameter int DEPTH      = 16,
    parameter int CYC_W      = 24,
    parameter int MAX_CYCLES = 100000
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        en,
    input  logic                                        reg_we,
    input  logic [REG_W-1:0]                            reg_sel,
    input  logic [DATA_W-1:0]                           reg_data,
    input  logic                                        mem_rd,
    input  logic                                        mem_wr,
    input  logic [ADDR_W-1:0]                           mem_addr,
    input  logic [DATA_W-1:0]                           mem_wdata,
    input  logic [DATA_W-1:0]                           mem_rdata,
    input  logic                                        halt,
    output logic                                        rec_valid,
    input  logic                                        rec_ready,
    output logic [CYC_W+5+REG_W+ADDR_W+2*DATA_W-1:0]    rec_data,
    output logic [CYC_W-1:0]                            cycle_count,
    output logic [CYC_W-1:0]                            inst_count,
    output logic [7:0]                                  drop_count,
    output logic                                        overflow,
    output logic                                        timeout,
    output logic                                        done
);

    localparam int REC_W = CYC_W + 5 + REG_W + ADDR_W + 2 * DATA_W;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CYC_W-1:0] CYC_LIMIT = CYC_W'(MAX_CYCLES);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_HALTED,
        ST_TIMEOUT
    } state_t;

    state_t             state_q, state_d;
    logic [CYC_W-1:0]   cycle_q, cycle_d;
    logic [CYC_W-1:0]   inst_q, inst_d;
    logic [7:0]         drop_q, drop_d;
    logic               overflow_q, overflow_d;
    logic               timeout_q, timeout_d;
    logic               done_q, done_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   occ_q, occ_d;
    logic [REC_W-1:0]   fifo_mem_q [DEPTH];

    logic               running;
    logic               active;
    logic               err;
    logic [DATA_W-1:0]  mem_data;
    logic [REC_W-1:0]   rec_word;
    logic               full;
    logic               pop;
    logic               push_ok;
    logic               drop;

    // Record assembly; fields belonging to flags that are not set are zeroed.
    always_comb begin
        running  = (state_q == ST_RUN);
        active   = running && (reg_we || mem_rd || mem_wr || halt);
        err      = mem_rd && mem_wr;
        mem_data = '0;
        if (mem_wr) begin
            mem_data = mem_wdata;
        end else if (mem_rd) begin
            mem_data = mem_rdata;
        end
        rec_word = {cycle_q,
                    err, halt, mem_wr, mem_rd, reg_we,
                    reg_we ? reg_sel : {REG_W{1'b0}},
                    reg_we ? reg_data : {DATA_W{1'b0}},
                    (mem_rd || mem_wr) ? mem_addr : {ADDR_W{1'b0}},
                    mem_data};
    end

    always_comb begin
        state_d   = state_q;
        cycle_d   = cycle_q;
        inst_d    = inst_q;
        timeout_d = timeout_q;
        done_d    = (state_q == ST_HALTED) || (state_q == ST_TIMEOUT);
        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                cycle_d = cycle_q + CYC_W'(1);
                if (halt || reg_we || mem_wr) begin
                    inst_d = inst_q + CYC_W'(1);
                end
                // halt wins over the watchdog when both land on the same edge
                if (halt) begin
                    state_d = ST_HALTED;
                end else if (cycle_d == CYC_LIMIT) begin
                    state_d   = ST_TIMEOUT;
                    timeout_d = 1'b1;
                end
            end
            ST_HALTED:  state_d = ST_HALTED;
            ST_TIMEOUT: state_d = ST_TIMEOUT;
            default:    state_d = ST_IDLE;
        endcase
    end

    // A push into a full FIFO still succeeds when the head leaves on the same edge.
    always_comb begin
        rec_valid  = (occ_q != '0);
        full       = (occ_q == FULL_CNT);
        pop        = rec_valid && rec_ready;
        push_ok    = active && (!full || pop);
        drop       = active && full && !pop;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        occ_d      = occ_q;
        drop_d     = drop_q;
        overflow_d = overflow_q || drop;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_ok, pop})
            2'b10:   occ_d = occ_q + CNT_W'(1);
            2'b01:   occ_d = occ_q - CNT_W'(1);
            default: occ_d = occ_q;
        endcase
        if (drop && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cycle_q    <= '0;
            inst_q     <= '0;
            drop_q     <= '0;
            overflow_q <= 1'b0;
            timeout_q  <= 1'b0;
            done_q     <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
        end else begin
            state_q    <= state_d;
            cycle_q    <= cycle_d;
            inst_q     <= inst_d;
            drop_q     <= drop_d;
            overflow_q <= overflow_d;
            timeout_q  <= timeout_d;
            done_q     <= done_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            fifo_mem_q[wr_ptr_q] <= rec_word;
        end
    end

    assign rec_data    = rec_valid ? fifo_mem_q[rd_ptr_q] : '0;
    assign cycle_count = cycle_q;
    assign inst_count  = inst_q;
    assign drop_count  = drop_q;
    assign overflow    = overflow_q;
    assign timeout     = timeout_q;
    assign done        = done_q;

endmodule
